apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB3/APB4 requester (master) that turns single-beat commands from an internal command/response port into compliant APB SETUP/ACCESS transfers.
- Drives the same APB bus the UART register block's APB slave answers.
- Used by the UART-to-register bridge and by the bench to reach the slave.
- Adds a programmable wait-state timeout so a stalled slave cannot hang the requester.

Parameters:
ADDR_W, 12, APB address width (paddr, cmd_addr)
DATA_W, 32, data width (pwdata, prdata, cmd_wdata, rsp_rdata); pstrb width = DATA_W/8
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  in  1  clock, all logic on rising edge
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_err  out  1  pslverr seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes
pready  in  1  slave ready
prdata  in  DATA_W  slave read data
pslverr  in  1  slave error

Behaviour:
- Reset (presetn low, async):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - Wait counter cleared.
- cmd_ready = (state == IDLE), combinational; it is 1 in the first cycle after reset release.
- Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready.
  - Accept latches addr, write, wdata and strb into paddr, pwrite, pwdata, pstrb.
  - On reads, pstrb is forced to 0.
  - cmd_* may change freely after acceptance.
- FSM (apb_state_t):
  - IDLE:
    - psel = 0, penable = 0.
    - On accept -> SETUP, else stay.
  - SETUP:
    - psel = 1, penable = 0.
    - Exactly one cycle, then -> ACCESS.
    - Wait counter cleared.
  - ACCESS:
    - psel = 1, penable = 1.
    - pready = 1 -> IDLE; capture response.
    - pready = 0 -> counter + 1.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with pready still 0 -> IDLE as an aborted response.
- Bus stability: paddr, pwrite, pwdata and pstrb are held from SETUP through the last ACCESS cycle.
  - They keep their values in IDLE (no bus glitching); only the next accept updates them.
- Response (registered): rsp_valid pulses high for exactly 1 cycle, in the cycle after the terminating ACCESS edge, with:
  - rsp_rdata = prdata for a read completed with pready, else 0.
  - rsp_err = pslverr (sampled only when pready = 1), or 1 on timeout.
  - rsp_timeout = 1 only on abort.
- rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- Throughput:
  - Minimum transfer is 2 APB cycles (SETUP + ACCESS) plus 1 IDLE cycle.
  - Back-to-back commands therefore start every 3 cycles with no wait states.
  - rsp_valid of transfer N coincides with the IDLE cycle in which N+1 may be accepted.
- Timeout count: with TIMEOUT = T, an abort occurs after exactly T ACCESS cycles with pready low.
- Simultaneous pready = 1 on the final timeout cycle: treated as normal completion, not a timeout.
- Reset mid-transfer:
  - psel and penable drop immediately (async).
  - No rsp_valid is issued for the lost command.
- cmd_valid while busy: ignored (cmd_ready = 0); the requester must hold it.

Decomposition:
- Package apb_pkg holds:
  - apb_state_t enum {IDLE, SETUP, ACCESS}.
  - Localparams APB_ADDR_W = 12, APB_DATA_W = 32, APB_STRB_W = APB_DATA_W/8.
  - The shared response struct {rdata, err, timeout}.
- The package is also imported by the existing APB slave.
- One natural sub-module: apb_wait_timer. It is a counter with clear, enable and terminal-count outputs, parameterised by TIMEOUT, with the TIMEOUT = 0 disable handled inside.

Test Plan:
- Write, no wait: cmd write addr 0x004, wdata 0xA5A5_1234, strb 0xF; slave pready = 1.
  - Expect SETUP then ACCESS with psel/penable 1/0 then 1/1, paddr 0x004, pwdata held, pstrb 0xF.
  - Expect rsp_valid 1 cycle later with rsp_err 0.
- Read, 2 wait states: cmd read addr 0x008; pready low 2 ACCESS cycles then high with prdata 0xDEAD_BEEF.
  - Expect rsp_rdata 0xDEAD_BEEF, pstrb 0 throughout, paddr stable for all 3 ACCESS cycles.
- Slave error: write to 0xFFC; pready = 1, pslverr = 1 -> rsp_err 1, rsp_timeout 0.
- Timeout: TIMEOUT = 4, pready stuck 0.
  - Expect psel to drop after 4 ACCESS cycles, rsp_valid with rsp_err 1, rsp_timeout 1, rsp_rdata 0.
  - Repeat with pready = 1 on the 4th cycle -> normal completion.
- Back-to-back: cmd_valid held for write 0x000 then read 0x004; expect accepts exactly 3 cycles apart and 2 rsp_valid pulses.
- Reset mid-ACCESS: assert presetn low during a wait state -> psel and penable 0 immediately, no rsp_valid; cmd_ready 1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types and widths for the requester and the register-block slave.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 12;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// Wait-state counter: cleared in SETUP, counts stalled ACCESS cycles, flags the last allowed one.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at the terminal value; a zero TIMEOUT never flags.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_c_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_c_o = (TIMEOUT != 0) && (cnt_q == TC_VAL);

endmodule : apb_wait_timer

// File: rtl/apb_master.sv
// APB3/APB4 requester: single-beat command port to SETUP/ACCESS transfers with wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;

  apb_state_t        state_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              tmr_tc;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .clr_i   (state_q == SETUP),
    .en_i    ((state_q == ACCESS) && !pready),
    .tc_c_o  (tmr_tc)
  );

  assign cmd_ready = (state_q == IDLE);

  // Bus fields are only rewritten on accept, so they hold through ACCESS and idle periods.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            pwdata_q  <= cmd_wdata;
            pstrb_q   <= cmd_write ? cmd_strb : '0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // pready wins over a coincident terminal count.
          if (pready) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (tmr_tc) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: vector table with an APB slave model and a response scoreboard.
module tb_apb_master;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int TO = 4;

  logic          pclk;
  logic          presetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;   // pready-low ACCESS cycles; >= TO means never ready
    logic [DW-1:0] prd;
    logic          slverr;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    logic          e_to;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse pops and checks one expected record.
  always @(negedge pclk) begin : rsp_mon
    exp_t e;
    if (presetn === 1'b1 && rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      end
    end
  end

  task automatic wait_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_ready"}, 64'(ok), 64'(1));
  endtask

  task automatic do_xfer(input vec_t v, input string tag);
    bit ok;
    int n_acc;
    logic [SW-1:0] e_strb;
    wait_ready(tag, ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb;
    sb_q.push_back('{v.e_rdata, v.e_err, v.e_to});
    e_strb = v.wr ? v.strb : '0;
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = ~v.addr;
    cmd_wdata = ~v.wdata; cmd_strb = ~v.strb;
    @(negedge pclk);
    chk({tag, "_setup_sel_en"}, 64'({psel, penable}), 64'(2'b10));
    chk({tag, "_setup_paddr"}, 64'(paddr), 64'(v.addr));
    chk({tag, "_setup_pwrite"}, 64'(pwrite), 64'(v.wr));
    chk({tag, "_setup_pwdata"}, 64'(pwdata), 64'(v.wdata));
    chk({tag, "_setup_pstrb"}, 64'(pstrb), 64'(e_strb));
    n_acc = (v.waits >= TO) ? TO : v.waits + 1;
    for (int i = 0; i < n_acc; i++) begin
      @(negedge pclk);
      chk({tag, "_acc_sel_en"}, 64'({psel, penable}), 64'(2'b11));
      chk({tag, "_acc_paddr"}, 64'(paddr), 64'(v.addr));
      chk({tag, "_acc_pstrb"}, 64'(pstrb), 64'(e_strb));
      pready = (i == v.waits); prdata = v.prd; pslverr = v.slverr;
    end
    @(negedge pclk);
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h5A5A_5A5A;
    chk({tag, "_end_sel_en"}, 64'({psel, penable}), 64'(2'b00));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_end_paddr_held"}, 64'(paddr), 64'(v.addr));
    @(negedge pclk);
    chk({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_err_hold"}, 64'(rsp_err), 64'(v.e_err));
  endtask

  vec_t vecs[7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int c, n_acc, n_rsp0;
    int acc_cyc[2];
    bit acc;

    //            wr    addr     wdata          strb   waits prd            slverr e_rdata        e_err e_to
    vecs[0] = '{1'b1, 12'h004, 32'hA5A5_1234, 4'hF, 0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 12'h008, 32'h0BAD_0BAD, 4'hF, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 12'hFFC, 32'h0000_00FF, 4'hF, 0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 12'h010, 32'h1111_2222, 4'h3, 4, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 12'h014, 32'h3333_4444, 4'hF, 3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 12'h020, 32'h7654_3210, 4'h5, 1, 32'h9999_9999, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 12'h7F0, 32'h0000_0000, 4'hF, 0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0};

    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_sel_en", 64'({psel, penable, pwrite}), 64'(0));
    chk("rst_bus", 64'({paddr, pwdata, pstrb}), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 64'(0));
    presetn = 1'b1;
    #1 chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 7; i++) do_xfer(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: cmd_valid held across two commands, slave always ready.
    wait_ready("b2b", ok);
    n_rsp0 = n_rsp;
    pready = 1'b1; prdata = 32'h1357_9BDF; pslverr = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h000;
    cmd_wdata = 32'h0F0F_0F0F; cmd_strb = 4'hF;
    sb_q.push_back('{32'h0, 1'b0, 1'b0});
    c = 0; n_acc = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    while (n_acc < 2 && c < 20) begin
      if (c > 0) @(negedge pclk);
      acc = (cmd_valid === 1'b1 && cmd_ready === 1'b1);
      if (acc) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      @(posedge pclk); #1;
      if (acc && n_acc == 1) begin
        cmd_write = 1'b0; cmd_addr = 12'h004;
        sb_q.push_back('{32'h1357_9BDF, 1'b0, 1'b0});
      end else if (acc && n_acc == 2) begin
        cmd_valid = 1'b0;
      end
      c++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 64'(n_acc), 64'(2));
    chk("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'(3));
    repeat (4) @(negedge pclk);
    pready = 1'b0;
    chk("b2b_rsp_count", 64'(n_rsp - n_rsp0), 64'(2));

    // Reset during an ACCESS wait state: bus drops at once, no response for the lost command.
    wait_ready("rst_mid", ok);
    n_rsp0 = n_rsp;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_mid_in_access", 64'({psel, penable}), 64'(2'b11));
    #2 presetn = 1'b0;
    #1 chk("rst_mid_sel_en", 64'({psel, penable}), 64'(0));
    @(negedge pclk);
    chk("rst_mid_no_rsp", 64'(rsp_valid), 64'(0));
    presetn = 1'b1;
    #1 chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (6) @(negedge pclk);
    chk("rst_mid_rsp_count", 64'(n_rsp - n_rsp0), 64'(0));
    chk("rst_mid_idle", 64'({psel, penable}), 64'(0));

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_apb_master
